// File: rtl/writeback_unit.sv
// Writeback stage: latches ALU results into acc/flags and retires them to the
// register file (one-cycle strobe) or to word/bit memory (req/ack with timeout).
module writeback_unit #(
    parameter int WIDTH   = 8,
    parameter int IWIDTH  = 8,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [IWIDTH-1:0] wb_op,
    input  logic [WIDTH-1:0]  wb_result,
    input  logic              wb_c,
    input  logic              wb_b,
    input  logic              wb_flag_valid,
    input  logic [1:0]        wb_dest,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic [WIDTH-1:0]  acc,
    output logic              carry_flag,
    output logic              borrow_flag,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [WIDTH-1:0]  rf_wdata,
    output logic              mem_req,
    output logic              mem_bit,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic              mem_ack,
    input  logic              err_clr,
    output logic              err_timeout
);
    typedef enum logic [1:0] {IDLE, RF_WR, MEM_WAIT} state_t;

    localparam logic [IWIDTH-1:0] OP_S   = IWIDTH'(8'h1B);
    localparam logic [IWIDTH-1:0] OP_R   = IWIDTH'(8'h1C);
    localparam logic [IWIDTH-1:0] OP_ST  = IWIDTH'(8'h1D);
    localparam logic [IWIDTH-1:0] OP_STN = IWIDTH'(8'h1E);
    localparam logic [7:0]        CNT_LAST = 8'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic                carry_q, carry_d, borrow_q, borrow_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [WIDTH-1:0]    rf_wdata_q, rf_wdata_d;
    logic                mem_req_q, mem_req_d, mem_bit_q, mem_bit_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic                err_q, err_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                keep_acc, suppress, timeout_hit;

    // S/R are conditional stores gated by the pre-update acc LSB.
    assign keep_acc = (wb_op == OP_S) || (wb_op == OP_R) || (wb_op == OP_ST) || (wb_op == OP_STN);
    assign suppress = (wb_dest == 2'b00) || (((wb_op == OP_S) || (wb_op == OP_R)) && !acc_q[0]);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        borrow_d    = borrow_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        mem_req_d   = mem_req_q;
        mem_bit_d   = mem_bit_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (wb_valid) begin
                    if (!keep_acc) acc_d = wb_result;
                    if (wb_flag_valid) begin
                        carry_d  = wb_c;
                        borrow_d = wb_b;
                    end
                    if (!suppress) begin
                        if (wb_dest == 2'b01) begin
                            state_d    = RF_WR;
                            rf_we_d    = 1'b1;
                            rf_waddr_d = wb_addr;
                            rf_wdata_d = wb_result;
                        end else begin
                            state_d     = MEM_WAIT;
                            mem_req_d   = 1'b1;
                            mem_bit_d   = wb_dest[0];
                            mem_addr_d  = wb_addr;
                            mem_wdata_d = wb_dest[0] ? {{(WIDTH-1){1'b0}}, wb_result[0]} : wb_result;
                            cnt_d       = 8'd0;
                        end
                    end
                end
            end
            RF_WR: state_d = IDLE;
            MEM_WAIT: begin
                // Ack on the terminal count wins over the timeout.
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = err_q;
        if (timeout_hit)  err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            borrow_q    <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_bit_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            borrow_q    <= borrow_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            mem_req_q   <= mem_req_d;
            mem_bit_q   <= mem_bit_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign wb_ready    = (state_q == IDLE);
    assign acc         = acc_q;
    assign carry_flag  = carry_q;
    assign borrow_flag = borrow_q;
    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign mem_req     = mem_req_q;
    assign mem_bit     = mem_bit_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign err_timeout = err_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: driver pushes expected writes, a
// negedge monitor pops them when rf_we pulses or a mem_req burst appears.
module tb_writeback_unit;
    localparam int T = 16;

    logic       clk = 0, rst_n = 0;
    logic       wb_valid = 0, wb_ready;
    logic [7:0] wb_op = 0, wb_result = 0, wb_addr = 0;
    logic       wb_c = 0, wb_b = 0, wb_flag_valid = 0;
    logic [1:0] wb_dest = 0;
    logic [7:0] acc, rf_waddr, rf_wdata, mem_addr, mem_wdata;
    logic       carry_flag, borrow_flag, rf_we, mem_req, mem_bit;
    logic       mem_ack = 0, err_clr = 0, err_timeout;

    writeback_unit #(.WIDTH(8), .IWIDTH(8), .ADDR_W(8), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_op(wb_op), .wb_result(wb_result), .wb_c(wb_c), .wb_b(wb_b),
        .wb_flag_valid(wb_flag_valid), .wb_dest(wb_dest), .wb_addr(wb_addr),
        .acc(acc), .carry_flag(carry_flag), .borrow_flag(borrow_flag),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_req(mem_req), .mem_bit(mem_bit), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .err_clr(err_clr),
        .err_timeout(err_timeout));

    always #5 clk = ~clk;

    typedef struct {
        bit         is_mem;
        logic       bit_w;
        logic [7:0] addr;
        logic [7:0] data;
        int         len;
    } exp_t;

    exp_t       expq[$];
    int         n_chk = 0, n_fail = 0;
    bit         mon_en = 1;
    logic [7:0] acc_m = 0;
    logic       c_m = 0, b_m = 0, err_m = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: consumes expected writes as the DUT performs them.
    bit   in_burst = 0;
    int   blen = 0;
    exp_t cur;
    always @(negedge clk) begin
        if (!mon_en || !rst_n) begin
            in_burst = 0;
        end else begin
            if (rf_we && mem_req) check("rf_we_and_mem_req", 1, 0);
            if (rf_we) begin
                if (expq.size() == 0) check("unexpected_rf_we", 1, 0);
                else begin
                    cur = expq.pop_front();
                    check("rf_kind", {31'd0, cur.is_mem}, 0);
                    check("rf_waddr", rf_waddr, cur.addr);
                    check("rf_wdata", rf_wdata, cur.data);
                    check("rf_ready_low", wb_ready, 0);
                end
            end
            if (mem_req && !in_burst) begin
                if (expq.size() == 0) check("unexpected_mem_req", 1, 0);
                else begin
                    cur = expq.pop_front();
                    check("mem_kind", {31'd0, cur.is_mem}, 1);
                    check("mem_bit", mem_bit, cur.bit_w);
                    check("mem_addr", mem_addr, cur.addr);
                    check("mem_wdata", mem_wdata, cur.data);
                end
                in_burst = 1;
                blen = 1;
            end else if (mem_req) begin
                blen++;
                if (mem_addr !== cur.addr || mem_wdata !== cur.data || mem_bit !== cur.bit_w)
                    check("mem_stable", 1, 0);
            end else if (in_burst) begin
                in_burst = 0;
                check("mem_req_len", blen, cur.len);
            end
        end
    end

    task automatic wait_ready();
        int g = 0;
        while (!wb_ready && g < 60) begin
            @(negedge clk);
            g++;
        end
        if (!wb_ready) check("ready_timeout", 0, 1);
    endtask

    // One transaction; d = cycle on which mem_ack is raised (d > T: never).
    task automatic issue(input logic [7:0] op, input logic [7:0] res, input logic c,
                         input logic b, input logic fv, input logic [1:0] dest,
                         input logic [7:0] addr, input int d, input bit hold_clr);
        bit   keep, supp;
        exp_t e;
        @(negedge clk);
        wait_ready();
        wb_valid = 1; wb_op = op; wb_result = res; wb_c = c; wb_b = b;
        wb_flag_valid = fv; wb_dest = dest; wb_addr = addr;
        mem_ack = 1'($urandom_range(0, 1));
        @(posedge clk);
        keep = (op >= 8'h1B && op <= 8'h1E);
        supp = (dest == 2'b00) || ((op == 8'h1B || op == 8'h1C) && !acc_m[0]);
        if (!keep) acc_m = res;
        if (fv) begin c_m = c; b_m = b; end
        if (!supp) begin
            e.is_mem = (dest != 2'b01);
            e.bit_w  = (dest == 2'b11);
            e.addr   = addr;
            e.data   = (dest == 2'b11) ? {7'd0, res[0]} : res;
            e.len    = (d <= T) ? d : T;
            expq.push_back(e);
        end
        @(negedge clk);
        wb_valid = 0;
        mem_ack = 0;
        check("acc", acc, acc_m);
        check("carry_flag", carry_flag, c_m);
        check("borrow_flag", borrow_flag, b_m);
        check("wb_ready_after_accept", wb_ready, supp);
        if (!supp && dest != 2'b01) begin
            for (int k = 1; k <= T + 4; k++) begin
                mem_ack = (k == d);
                err_clr = hold_clr;
                @(negedge clk);
                mem_ack = 0;
                err_clr = 0;
                if (!mem_req) break;
            end
            if (hold_clr) err_m = 0;
            if (d > T) err_m = 1;
            check("err_after_mem", err_timeout, err_m);
            check("idle_after_mem", wb_ready, 1);
        end else if (!supp) begin
            mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            mem_ack = 0;
        end
        check("no_stray_mem_req", mem_req, 0);
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1;
        @(posedge clk);
        err_m = 0;
        @(negedge clk);
        err_clr = 0;
        check("err_cleared", err_timeout, err_m);
    endtask

    initial begin
        logic [7:0] op;
        logic [1:0] dst;
        #12;
        check("rst_acc", acc, 0);
        check("rst_ready", wb_ready, 1);
        check("rst_strobes", {rf_we, mem_req, mem_bit, err_timeout, carry_flag, borrow_flag}, 0);
        check("rst_addrs", {rf_waddr, rf_wdata, mem_addr, mem_wdata}, 0);
        rst_n = 1;

        issue(8'h07, 8'h5A, 1, 0, 1, 2'b00, 8'h00, 0, 0);     // ADD, no write
        issue(8'h07, 8'h33, 0, 0, 0, 2'b00, 8'h00, 0, 0);
        issue(8'h1D, 8'h33, 0, 0, 0, 2'b01, 8'h04, 0, 0);     // ST to RF
        issue(8'h07, 8'hA5, 0, 1, 1, 2'b11, 8'h10, 3, 0);     // bit mem, ack on 3rd
        issue(8'h07, 8'h3C, 0, 0, 0, 2'b10, 8'h20, 99, 0);    // no ack -> timeout
        clear_err();
        issue(8'h07, 8'h11, 0, 0, 0, 2'b10, 8'h21, T, 0);     // ack on terminal count
        issue(8'h07, 8'h02, 0, 0, 0, 2'b00, 8'h00, 0, 0);
        issue(8'h1B, 8'h77, 0, 0, 0, 2'b01, 8'h05, 0, 0);     // S suppressed
        issue(8'h07, 8'h01, 0, 0, 0, 2'b00, 8'h00, 0, 0);
        issue(8'h1B, 8'h77, 0, 0, 0, 2'b01, 8'h05, 0, 0);     // S fires
        issue(8'h07, 8'h44, 0, 0, 0, 2'b10, 8'h22, 99, 1);    // timeout with err_clr held
        clear_err();

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0: op = 8'h1B;
                1: op = 8'h1C;
                2: op = 8'h1D;
                3: op = 8'h1E;
                default: op = 8'($urandom);
            endcase
            dst = 2'($urandom);
            issue(op, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), dst,
                  8'($urandom), $urandom_range(1, T + 2), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 9) == 0) clear_err();
        end

        // Reset in the middle of a memory wait.
        @(negedge clk);
        wait_ready();
        mon_en = 0;
        wb_valid = 1; wb_op = 8'h07; wb_result = 8'h9C; wb_dest = 2'b10;
        wb_addr = 8'h30; wb_flag_valid = 1; wb_c = 1; wb_b = 1;
        @(negedge clk);
        wb_valid = 0;
        check("mem_req_before_reset", mem_req, 1);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("async_rst_mem_req", mem_req, 0);
        check("async_rst_ready", wb_ready, 1);
        check("async_rst_outs", {acc, carry_flag, borrow_flag, rf_we, mem_bit, err_timeout}, 0);
        check("async_rst_addrs", {rf_waddr, rf_wdata, mem_addr, mem_wdata}, 0);
        @(negedge clk);
        rst_n = 1;
        acc_m = 0; c_m = 0; b_m = 0; err_m = 0;
        repeat (3) @(negedge clk);
        check("post_reset_quiet", {mem_req, rf_we, err_timeout}, 0);
        mon_en = 1;
        issue(8'h07, 8'h66, 0, 0, 0, 2'b01, 8'h07, 0, 0);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data path width (matches ALU result width).
REQ-002 SHALL have parameter IWIDTH, default 8, meaning opcode width.
REQ-003 SHALL have parameter ADDR_W, default 8, meaning register-file/memory address width.
REQ-004 SHALL have parameter TIMEOUT, default 16, meaning max MEM_WAIT cycles before abort (range 2..255).
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port wb_valid  input  1  execute stage presents a result.
REQ-008 SHALL have port wb_ready  output  1  block accepts a result this cycle.
REQ-009 SHALL have port wb_op  input  IWIDTH  opcode of the result.
REQ-010 SHALL have port wb_result  input  WIDTH  ALU result.
REQ-011 SHALL have ports wb_c, wb_b, wb_flag_valid  input  1 each  ALU carry, borrow, flag-valid.
REQ-012 SHALL have port wb_dest  input  2  destination: 00 none, 01 register file, 10 word memory, 11 bit memory.
REQ-013 SHALL have port wb_addr  input  ADDR_W  destination address.
REQ-014 SHALL have port acc  output  WIDTH  current-result register.
REQ-015 SHALL have ports carry_flag, borrow_flag  output  1 each  registered flags, fed back to ALU carry/borrow inputs.
REQ-016 SHALL have ports rf_we  output  1, rf_waddr  output  ADDR_W, rf_wdata  output  WIDTH  register-file write.
REQ-017 SHALL have ports mem_req  output  1, mem_bit  output  1, mem_addr  output  ADDR_W, mem_wdata  output  WIDTH, mem_ack  input  1  memory write handshake.
REQ-018 SHALL have ports err_clr  input  1 and err_timeout  output  1 (sticky timeout error).

Function
REQ-019 SHALL implement FSM states IDLE, RF_WR, MEM_WAIT; wb_ready = 1 only in IDLE (combinational from state).
REQ-020 Accept SHALL occur on rising edge with wb_valid=1 and state=IDLE; all wb_* inputs captured at that edge.
REQ-021 On accept, acc SHALL load wb_result unless wb_op is 0x1B, 0x1C, 0x1D or 0x1E (S, R, ST, STN), which leave acc unchanged.
REQ-022 On accept with wb_flag_valid=1, carry_flag<=wb_c and borrow_flag<=wb_b; otherwise flags hold.
REQ-023 acc and flag updates SHALL be visible the cycle after accept (latency 1).
REQ-024 Write is suppressed (FSM stays IDLE) when wb_dest=00, or when wb_op is 0x1B/0x1C and acc[0]=0 at accept (pre-update value).
REQ-025 Unsuppressed write with wb_dest=01: IDLE->RF_WR; rf_we=1 for exactly one cycle with rf_waddr=wb_addr, rf_wdata=wb_result; RF_WR->IDLE unconditionally.
REQ-026 Unsuppressed write with wb_dest=10/11: IDLE->MEM_WAIT; mem_req=1 from cycle after accept; mem_addr, mem_wdata stable while mem_req=1.
REQ-027 mem_bit=1 and mem_wdata={WIDTH-1 zeros, wb_result[0]} for wb_dest=11; mem_bit=0 and mem_wdata=wb_result for wb_dest=10.
REQ-028 In MEM_WAIT, edge with mem_ack=1 SHALL end transfer: mem_req=0 next cycle, state->IDLE.
REQ-029 Wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle; at count TIMEOUT-1 without ack, state->IDLE, mem_req drops, err_timeout<=1.
REQ-030 Ack in same cycle as terminal count SHALL be treated as success; err_timeout unchanged.
REQ-031 mem_ack outside MEM_WAIT SHALL be ignored.
REQ-032 err_timeout SHALL stay 1 until err_clr=1 at an edge; simultaneous timeout and err_clr SHALL leave err_timeout=1.
REQ-033 rf_we and mem_req SHALL never be 1 in the same cycle.

Reset
REQ-034 rst_n=0 SHALL immediately force state IDLE, acc=0, carry_flag=0, borrow_flag=0, rf_we=0, mem_req=0, mem_bit=0, rf_waddr=0, rf_wdata=0, mem_addr=0, mem_wdata=0, err_timeout=0, counter=0; wb_ready=1.
REQ-035 Reset asserted in MEM_WAIT or RF_WR SHALL abort the write with no error flagged; pending write is lost.

Verification
REQ-036 ADD: wb_op=0x07, wb_result=0x5A, wb_c=1, wb_flag_valid=1, wb_dest=00 -> next cycle acc=0x5A, carry_flag=1, wb_ready stays 1, no write strobes.
REQ-037 ST to RF: acc=0x33, wb_op=0x1D, wb_result=0x33, wb_dest=01, wb_addr=0x04 -> one-cycle rf_we, rf_waddr=0x04, rf_wdata=0x33, wb_ready=0 that cycle, acc=0x33.
REQ-038 Bit-memory write, ack after 3 cycles: wb_dest=11, wb_result=0xA5, wb_addr=0x10 -> mem_req=1 for 3 cycles, mem_bit=1, mem_wdata=0x01, then IDLE, err_timeout=0.
REQ-039 No ack: wb_dest=10 -> mem_req high exactly TIMEOUT cycles (16), then low, err_timeout=1; err_clr pulse -> err_timeout=0.
REQ-040 S with acc[0]=0, wb_dest=01 -> no rf_we, acc unchanged; repeat with acc=0x01 -> rf_we pulse.
REQ-041 rst_n low during MEM_WAIT -> mem_req=0 without clock edge, all outputs at reset values, err_timeout=0.
